// File: rtl/conv_window_mac_if.sv
// Window-beat in / result-pixel out handshake bundle for conv_window_mac.
// master drives beats and out_ready; slave is the MAC engine.
interface conv_window_mac_if #(
    parameter int DWIDTH = 16,
    parameter int KSIZE  = 3
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_last;
    logic [KSIZE*KSIZE*DWIDTH-1:0]   din;
    logic [KSIZE*KSIZE*DWIDTH-1:0]   win;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [DWIDTH-1:0]        dout;
    logic                            sat;

    modport master (
        output in_valid, in_last, din, win, out_ready,
        input  in_ready, out_valid, dout, sat
    );

    modport slave (
        input  in_valid, in_last, din, win, out_ready,
        output in_ready, out_valid, dout, sat
    );
endinterface

// File: rtl/conv_window_mac.sv
// KxK window multiply / adder-tree / channel-accumulate engine with round, rescale, saturate.
// Optional CONV_MAC_RELU_EN clamps negative results to zero after saturation.
module conv_window_mac #(
    parameter int DWIDTH    = 16,
    parameter int QWIDTH    = 11,
    parameter int KSIZE     = 3,
    parameter int ACC_GUARD = 8
) (
    input logic              clk,
    input logic              rst,
    conv_window_mac_if.slave bus
);
    localparam int TAPS = KSIZE * KSIZE;
    localparam int PW   = 2 * DWIDTH;
    localparam int SW   = PW + $clog2(TAPS);
    localparam int AW   = SW + ACC_GUARD;
    localparam int RW   = AW + 1;

    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (QWIDTH - 1);
    localparam logic signed [RW-1:0] MAXV = RW'((2 ** (DWIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

    logic signed [DWIDTH-1:0] d_tap  [TAPS];
    logic signed [DWIDTH-1:0] w_tap  [TAPS];
    logic signed [PW-1:0]     m_prod [TAPS];
    logic                     m_valid, m_last;
    logic                     s_valid, s_last;
    logic signed [SW-1:0]     s_sum;
    logic signed [SW-1:0]     tree_sum;
    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     acc_next;
    logic                     first;
    logic signed [RW-1:0]     rnd_sum;
    logic signed [RW-1:0]     r;
    logic signed [DWIDTH-1:0] res_d;
    logic                     res_sat;
    logic                     out_valid_q;
    logic signed [DWIDTH-1:0] dout_q;
    logic                     sat_q;
    logic                     stall;

    assign stall         = out_valid_q && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.sat       = sat_q;

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            d_tap[i] = $signed(bus.din[i*DWIDTH +: DWIDTH]);
            w_tap[i] = $signed(bus.win[i*DWIDTH +: DWIDTH]);
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            tree_sum = tree_sum + SW'(m_prod[i]);
        end
    end

    // The group's final value is formed from acc_next so the result lands on the same edge as the last sum.
    always_comb begin
        acc_next = first ? AW'(s_sum) : acc + AW'(s_sum);
        rnd_sum  = RW'(acc_next) + HALF;
        r        = rnd_sum >>> QWIDTH;
        res_d    = r[DWIDTH-1:0];
        res_sat  = 1'b0;
        if (r > MAXV) begin
            res_d   = MAXV[DWIDTH-1:0];
            res_sat = 1'b1;
        end else if (r < MINV) begin
            res_d   = MINV[DWIDTH-1:0];
            res_sat = 1'b1;
        end
`ifdef CONV_MAC_RELU_EN
        if (res_d < 0) begin
            res_d = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            s_valid     <= 1'b0;
            s_last      <= 1'b0;
            s_sum       <= '0;
            acc         <= '0;
            first       <= 1'b1;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                m_prod[i] <= '0;
            end
        end else if (!stall) begin
            m_valid <= bus.in_valid;
            m_last  <= bus.in_last;
            for (int i = 0; i < TAPS; i++) begin
                m_prod[i] <= PW'(d_tap[i]) * PW'(w_tap[i]);
            end
            s_valid <= m_valid;
            s_last  <= m_last;
            s_sum   <= tree_sum;
            if (s_valid) begin
                acc   <= acc_next;
                first <= s_last;
            end
            // Not stalled means any held result is being popped now, so a fresh result may replace it.
            if (s_valid && s_last) begin
                out_valid_q <= 1'b1;
                dout_q      <= res_d;
                sat_q       <= res_sat;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed self-checking bench for conv_window_mac (KSIZE=3, Q5.11).
// Results are captured by a negedge monitor and compared against hand-computed values.
module tb_conv_window_mac;
    localparam int DW = 16;
    localparam int KS = 3;
    localparam int TP = KS * KS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_beat_cyc = 0;

    logic signed [DW-1:0] q_d [$];
    logic                 q_s [$];
    int                   q_c [$];

    conv_window_mac_if #(.DWIDTH(DW), .KSIZE(KS)) bus ();

    conv_window_mac #(.DWIDTH(DW), .QWIDTH(11), .KSIZE(KS), .ACC_GUARD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_d.push_back(bus.dout);
            q_s.push_back(bus.sat);
            q_c.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_taps(input int d, input int w, input bit only0);
        for (int i = 0; i < TP; i++) begin
            bus.din[i*DW +: DW] = (only0 && i != 0) ? 16'sd0 : 16'(d);
            bus.win[i*DW +: DW] = (only0 && i != 0) ? 16'sd0 : 16'(w);
        end
    endtask

    task automatic beat(input int d, input int w, input bit only0, input bit last);
        set_taps(d, w, only0);
        bus.in_valid  = 1'b1;
        bus.in_last   = last;
        last_beat_cyc = cyc;
        step(1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_d, input int exp_s, input int exp_lat);
        int n;
        int got_d;
        int got_s;
        int got_c;
        n = 0;
        while (q_d.size() == 0 && n < 20) begin
            step(1);
            n++;
        end
        chk({tag, "_avail"}, int'(q_d.size() > 0), 1);
        if (q_d.size() > 0) begin
            got_d = int'(q_d.pop_front());
            got_s = int'(q_s.pop_front());
            got_c = q_c.pop_front();
            chk({tag, "_dout"}, got_d, exp_d);
            chk({tag, "_sat"}, got_s, exp_s);
            if (exp_lat >= 0) chk({tag, "_lat"}, got_c - last_beat_cyc, exp_lat);
        end
    endtask

    initial begin
        int neg_full;
        int neg_one;
`ifdef CONV_MAC_RELU_EN
        neg_full = 0;
        neg_one  = 0;
`else
        neg_full = -32768;
        neg_one  = -18432;
`endif
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        set_taps(0, 0, 1'b0);
        step(3);
        rst = 1'b0;

        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_sat", int'(bus.sat), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // 9 taps of 1.0*1.0 -> 9.0
        beat(2048, 2048, 1'b0, 1'b1);
        idle();
        check_result("one_beat", 18432, 0, 3);

        // 3 beats of 9 x 0.25 -> 6.75; nothing may appear before the last beat
        beat(1024, 1024, 1'b0, 1'b0);
        beat(1024, 1024, 1'b0, 1'b0);
        idle();
        step(6);
        chk("no_early_out", q_d.size(), 0);
        beat(1024, 1024, 1'b0, 1'b1);
        idle();
        check_result("three_beat", 13824, 0, 3);
        step(5);
        chk("no_extra_out", q_d.size(), 0);

        // 27.0 saturates both ways
        beat(2048, 2048, 1'b0, 1'b0);
        beat(2048, 2048, 1'b0, 1'b0);
        beat(2048, 2048, 1'b0, 1'b1);
        idle();
        check_result("sat_pos", 32767, 1, -1);
        beat(2048, -2048, 1'b0, 1'b0);
        beat(2048, -2048, 1'b0, 1'b0);
        beat(2048, -2048, 1'b0, 1'b1);
        idle();
        check_result("sat_neg", neg_full, 1, -1);

        // rounding half toward +inf
        beat(-1, 1024, 1'b1, 1'b1);
        idle();
        check_result("round_m1", 0, 0, -1);
        beat(3, 1024, 1'b1, 1'b1);
        idle();
        check_result("round_p3", 2, 0, -1);

        // two back-to-back results held by out_ready low
        bus.out_ready = 1'b0;
        beat(2048, 2048, 1'b0, 1'b1);
        beat(4096, 2048, 1'b1, 1'b1);
        idle();
        step(5);
        chk("stall_in_ready", int'(bus.in_ready), 0);
        chk("stall_out_valid", int'(bus.out_valid), 1);
        chk("stall_dout_held", int'(bus.dout), 18432);
        step(1);
        chk("stall_dout_held2", int'(bus.dout), 18432);
        chk("stall_no_pop", q_d.size(), 0);
        bus.out_ready = 1'b1;
        check_result("stall_first", 18432, 0, -1);
        check_result("stall_second", 4096, 0, -1);
        step(5);
        chk("stall_no_dup", q_d.size(), 0);

        // reset discards a partial negative group
        beat(2048, -2048, 1'b0, 1'b0);
        beat(2048, -2048, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        beat(2048, 2048, 1'b0, 1'b1);
        idle();
        check_result("after_rst", 18432, 0, 3);

        beat(2048, -2048, 1'b0, 1'b1);
        idle();
        check_result("neg_group", neg_one, 0, -1);

        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
